// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/HALTED controller that stops fetching on a misaligned or
// out-of-range PC.
//
//   state  | meaning
//   RUN    | fetching normally; honours stall and redirect
//   HALTED | bad PC seen; all registers frozen until reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;

  logic [31:0] word_idx;
  logic [31:0] pc_plus4;
  logic        pc_bad;

  // Memory is word-indexed, so the low byte-offset bits are dropped.
  assign word_idx  = {2'b00, pc_q[31:2]};
  assign imem_addr = word_idx;
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_bad    = (pc_q[1:0] != 2'b00) || (word_idx >= 32'(MEM_SIZE));

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic: redirect beats stall; a redirect to a bad target is
  // accepted and only faults when a fetch is actually attempted from it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          instr_d = 32'd0;
        end else if (!stall) begin
          if (pc_bad) begin
            state_d    = HALTED;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            valid_d    = 1'b0;
            instr_d    = 32'd0;
          end else begin
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
            count_d = count_q + 32'd1;
          end
        end
      end
      HALTED: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// plus a per-cycle comparison against a behavioural fetch model.
module tb_fetch_stage;

  localparam int MSIZE = 32;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] mem [MSIZE];

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit          model_on = 1'b0;
  bit          m_halted;
  logic [31:0] m_pc, m_instr, m_pc4, m_fault_pc, m_count;
  logic        m_valid, m_fault;

  fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_SIZE(MSIZE)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .fetch_count (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_data = (imem_addr < 32'(MSIZE)) ? mem[imem_addr[4:0]] : 32'hDEAD_BEEF;

  // Model: what the stage must hold after each edge, from the block's rules.
  always @(posedge clk) begin
    if (reset) begin
      model_on   = 1'b1;
      m_halted   = 1'b0;
      m_pc       = 32'h0;
      m_instr    = 32'h0;
      m_pc4      = 32'h0;
      m_valid    = 1'b0;
      m_fault    = 1'b0;
      m_fault_pc = 32'h0;
      m_count    = 32'h0;
    end else if (model_on && !m_halted) begin
      if (redirect) begin
        m_pc    = redirect_pc;
        m_valid = 1'b0;
        m_instr = 32'h0;
      end else if (!stall) begin
        if ((m_pc % 4) != 0 || (m_pc / 4) >= MSIZE) begin
          m_halted   = 1'b1;
          m_fault    = 1'b1;
          m_fault_pc = m_pc;
          m_valid    = 1'b0;
          m_instr    = 32'h0;
        end else begin
          m_instr = mem[m_pc / 4];
          m_pc4   = m_pc + 4;
          m_valid = 1'b1;
          m_pc    = m_pc + 4;
          m_count = m_count + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("m_imem_addr", imem_addr, m_pc / 4);
      check("m_instr", if_id_instr, m_instr);
      check("m_pc4", if_id_pc4, m_pc4);
      check("m_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      check("m_fault", {31'd0, fault}, {31'd0, m_fault});
      check("m_fault_pc", fault_pc, m_fault_pc);
      check("m_count", fetch_count, m_count);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_instr"}, if_id_instr, 32'h0);
    check({tag, "_pc4"}, if_id_pc4, 32'h0);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_fault_pc"}, fault_pc, 32'h0);
    check({tag, "_count"}, fetch_count, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < MSIZE; i++) mem[i] = 32'h1357_0000 + 32'(i);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // reset, then free run A,B,C
    step(); step();
    check_reset_state("rst0");
    reset = 1'b0;
    step();
    check("run_instr_A", if_id_instr, 32'h1357_0000);
    check("run_pc4_A", if_id_pc4, 32'd4);
    check("run_addr_1", imem_addr, 32'd1);
    step();
    check("run_instr_B", if_id_instr, 32'h1357_0001);
    check("run_pc4_B", if_id_pc4, 32'd8);
    check("run_addr_2", imem_addr, 32'd2);
    step();
    check("run_instr_C", if_id_instr, 32'h1357_0002);
    check("run_pc4_C", if_id_pc4, 32'd12);
    check("run_count_3", fetch_count, 32'd3);
    check("run_addr_3", imem_addr, 32'd3);

    // stall two cycles after A
    reset = 1'b1; step(); reset = 1'b0;
    step();
    check("st_instr_A", if_id_instr, 32'h1357_0000);
    stall = 1'b1;
    step(); step();
    check("st_hold_instr", if_id_instr, 32'h1357_0000);
    check("st_hold_addr", imem_addr, 32'd1);
    check("st_hold_count", fetch_count, 32'd1);
    check("st_hold_valid", {31'd0, if_id_valid}, 32'd1);
    stall = 1'b0;
    step();
    check("st_resume_B", if_id_instr, 32'h1357_0001);
    check("st_resume_count", fetch_count, 32'd2);

    // redirect while stalled
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    step();
    check("rd_valid", {31'd0, if_id_valid}, 32'd0);
    check("rd_instr", if_id_instr, 32'h0);
    check("rd_addr", imem_addr, 32'd8);
    check("rd_pc4_kept", if_id_pc4, 32'd8);
    check("rd_count_kept", fetch_count, 32'd2);
    stall = 1'b0; redirect = 1'b0;
    step();
    check("rd_instr_m8", if_id_instr, 32'h1357_0008);
    check("rd_pc4", if_id_pc4, 32'h24);
    check("rd_count", fetch_count, 32'd3);

    // run off the end of memory
    reset = 1'b1; step(); reset = 1'b0;
    repeat (32) step();
    check("oob_count32", fetch_count, 32'd32);
    check("oob_addr32", imem_addr, 32'd32);
    check("oob_nofault", {31'd0, fault}, 32'd0);
    step();
    check("oob_fault", {31'd0, fault}, 32'd1);
    check("oob_fault_pc", fault_pc, 32'h80);
    check("oob_valid", {31'd0, if_id_valid}, 32'd0);
    check("oob_count", fetch_count, 32'd32);
    redirect = 1'b1; redirect_pc = 32'h0;
    step(); step();
    check("halt_fault", {31'd0, fault}, 32'd1);
    check("halt_addr", imem_addr, 32'd32);
    check("halt_count", fetch_count, 32'd32);
    redirect = 1'b0;

    // reset while halted and stalled
    stall = 1'b1; reset = 1'b1;
    step();
    check_reset_state("rsth");
    reset = 1'b0; stall = 1'b0;
    step();
    check("rsth_fetch0", if_id_instr, 32'h1357_0000);
    check("rsth_count", fetch_count, 32'd1);

    // misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h6;
    step();
    check("mis_nofault", {31'd0, fault}, 32'd0);
    check("mis_addr", imem_addr, 32'd1);
    redirect = 1'b0;
    step();
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_fault_pc", fault_pc, 32'h6);
    check("mis_valid", {31'd0, if_id_valid}, 32'd0);
    reset = 1'b1;
    step();
    check("mis_rst_fault", {31'd0, fault}, 32'd0);
    check("mis_rst_addr", imem_addr, 32'd0);
    reset = 1'b0;
    step();
    check("mis_rst_fetch0", if_id_instr, 32'h1357_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
